// File: rtl/mem_unit_pkg.sv
// mem_unit_pkg
//   Shared definitions for the CPU instruction/data memory block:
//   data-access FSM state encoding, RW and preload-select encodings,
//   and an address range helper used by every range check.
package mem_unit_pkg;

  // Data-access FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // RW pin encoding.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // LD_SEL pin encoding.
  localparam logic LD_IMEM = 1'b0;
  localparam logic LD_DMEM = 1'b1;

  // True when addr falls inside a memory of 'depth' words.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/mem_unit_ram.sv
// mem_unit_ram
//   Word-addressed storage array with synchronous write and synchronous
//   (registered) read. Two write requests share the array each edge; when
//   both target the same word the "hi" request wins. Contents are never
//   cleared, so there is no reset input.
//
// Ports:
//   clk       in   clock
//   we_hi     in   high-priority write enable
//   waddr_hi  in   high-priority write address
//   wdata_hi  in   high-priority write data
//   we_lo     in   low-priority write enable
//   waddr_lo  in   low-priority write address
//   wdata_lo  in   low-priority write data
//   raddr     in   read address, sampled every edge
//   rdata     out  word at raddr as it was before this edge's writes
module mem_unit_ram #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 16,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              we_hi,
  input  logic [AW-1:0]     waddr_hi,
  input  logic [DATA_W-1:0] wdata_hi,
  input  logic              we_lo,
  input  logic [AW-1:0]     waddr_lo,
  input  logic [DATA_W-1:0] wdata_lo,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array update and read register; the hi write is issued last so it
  // overrides the lo write on an address collision.
  always_ff @(posedge clk) begin
    if (we_lo) begin
      mem_q[waddr_lo] <= wdata_lo;
    end
    if (we_hi) begin
      mem_q[waddr_hi] <= wdata_hi;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_unit.sv
// mem_unit
//   Instruction and data memory for the 16-bit CPU.
//   - Instruction port: ID is the IMEM word at the IA of the previous edge,
//     or 0 when that IA was out of range.
//   - Data port: request/ready handshake on DREQ/RDY with WAIT_STATES extra
//     cycles; read data is driven onto the shared DD bus only in the RDY
//     cycle. A write commits on the edge that enters RESP.
//   - Preload port: one word per cycle into IMEM or DMEM; while LD_EN is
//     high new data accesses are not accepted.
//   - ERR: sticky flag for any out-of-range IA, DA or LD_ADDR; cleared
//     only by RST.
//
// Ports:
//   CK       in     clock
//   RST      in     synchronous active-high reset
//   IA       in     instruction address
//   ID       out    instruction word (1-cycle latency)
//   DREQ     in     data access request (sampled in IDLE only)
//   DA       in     data address
//   RW       in     1 = read, 0 = write
//   DD       inout  data bus (write data in, read data out in RDY cycle)
//   RDY      out    one-cycle completion pulse
//   LD_EN    in     preload write enable
//   LD_SEL   in     preload target (0 = IMEM, 1 = DMEM)
//   LD_ADDR  in     preload address
//   LD_DATA  in     preload word
//   ERR      out    sticky out-of-range flag
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int IDEPTH      = 128,
  parameter int DDEPTH      = 128,
  parameter int WAIT_STATES = 0
) (
  input  logic              CK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] IA,
  output logic [DATA_W-1:0] ID,
  input  logic              DREQ,
  input  logic [ADDR_W-1:0] DA,
  input  logic              RW,
  inout  wire  [DATA_W-1:0] DD,
  output logic              RDY,
  input  logic              LD_EN,
  input  logic              LD_SEL,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              ERR
);

  localparam int IAW = (IDEPTH > 1) ? $clog2(IDEPTH) : 1;
  localparam int DAW = (DDEPTH > 1) ? $clog2(DDEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  // FSM and latched request
  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   da_q, da_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                oob_q, oob_d;

  // Registered outputs / flags
  logic                rdy_q, rdy_d;
  logic                dd_oe_q, dd_oe_d;
  logic                id_ok_q, id_ok_d;
  logic                err_q, err_d;

  // Combinational helpers
  logic                accept_s;
  logic                enter_resp_s;
  logic                dm_we_s;
  logic                ld_in_range_s;
  logic                im_ld_we_s;
  logic                dm_ld_we_s;
  logic [DATA_W-1:0]   im_rd_s;
  logic [DATA_W-1:0]   dm_rd_s;

  // Next-state logic for the data-access FSM and its latched request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    da_d     = da_q;
    rw_d     = rw_q;
    wd_d     = wd_q;
    oob_d    = oob_q;
    accept_s = 1'b0;
    case (state_q)
      IDLE: begin
        // A pending preload takes the cycle; the request waits.
        if (DREQ && !LD_EN) begin
          accept_s = 1'b1;
          da_d     = DA;
          rw_d     = RW;
          wd_d     = DD;
          oob_d    = !addr_in_range(32'(DA), 32'(DDEPTH));
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The *_d request fields hold the access in progress on every cycle
  // (live inputs on the accepting edge, latched values afterwards), so the
  // DMEM port can use them directly whether or not wait states exist.
  assign enter_resp_s  = (state_d == RESP) && (state_q != RESP);
  assign dm_we_s       = enter_resp_s && (rw_d == RW_WRITE) && !oob_d && !RST;
  assign ld_in_range_s = (LD_SEL == LD_IMEM) ? addr_in_range(32'(LD_ADDR), 32'(IDEPTH))
                                             : addr_in_range(32'(LD_ADDR), 32'(DDEPTH));
  assign im_ld_we_s    = LD_EN && (LD_SEL == LD_IMEM) && ld_in_range_s;
  assign dm_ld_we_s    = LD_EN && (LD_SEL == LD_DMEM) && ld_in_range_s;

  // Next values of the registered outputs and the sticky error flag.
  always_comb begin
    rdy_d   = enter_resp_s;
    dd_oe_d = enter_resp_s && (rw_d == RW_READ);
    id_ok_d = addr_in_range(32'(IA), 32'(IDEPTH));
    err_d   = err_q
            | !id_ok_d
            | (accept_s && oob_d)
            | (LD_EN && !ld_in_range_s);
  end

  // State register for the FSM, request latch and output flags.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      da_q    <= {ADDR_W{1'b0}};
      rw_q    <= RW_READ;
      wd_q    <= {DATA_W{1'b0}};
      oob_q   <= 1'b0;
      rdy_q   <= 1'b0;
      dd_oe_q <= 1'b0;
      id_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      da_q    <= da_d;
      rw_q    <= rw_d;
      wd_q    <= wd_d;
      oob_q   <= oob_d;
      rdy_q   <= rdy_d;
      dd_oe_q <= dd_oe_d;
      id_ok_q <= id_ok_d;
      err_q   <= err_d;
    end
  end

  mem_unit_ram #(
    .DEPTH  (IDEPTH),
    .DATA_W (DATA_W),
    .AW     (IAW)
  ) u_imem (
    .clk      (CK),
    .we_hi    (1'b0),
    .waddr_hi ({IAW{1'b0}}),
    .wdata_hi ({DATA_W{1'b0}}),
    .we_lo    (im_ld_we_s),
    .waddr_lo (LD_ADDR[IAW-1:0]),
    .wdata_lo (LD_DATA),
    .raddr    (IA[IAW-1:0]),
    .rdata    (im_rd_s)
  );

  // The data write is on the high-priority side so it beats a same-word
  // preload on the same edge.
  mem_unit_ram #(
    .DEPTH  (DDEPTH),
    .DATA_W (DATA_W),
    .AW     (DAW)
  ) u_dmem (
    .clk      (CK),
    .we_hi    (dm_we_s),
    .waddr_hi (da_d[DAW-1:0]),
    .wdata_hi (wd_d),
    .we_lo    (dm_ld_we_s),
    .waddr_lo (LD_ADDR[DAW-1:0]),
    .wdata_lo (LD_DATA),
    .raddr    (da_d[DAW-1:0]),
    .rdata    (dm_rd_s)
  );

  // Out-of-range reads return zero; the bus is released outside RDY.
  assign DD  = dd_oe_q ? (oob_q ? {DATA_W{1'b0}} : dm_rd_s) : {DATA_W{1'bz}};
  assign ID  = id_ok_q ? im_rd_s : {DATA_W{1'b0}};
  assign RDY = rdy_q;
  assign ERR = err_q;

endmodule

// File: doc/mem_unit.md
# mem_unit

Parametrised, synthesisable instruction and data memory for the 16-bit CPU. It replaces the behavioural IMEM/DMEM arrays in the CPU simulation harness. It serves instruction fetch on IA/ID and data accesses on the shared bidirectional DD bus. It adds configurable data wait states with a ready handshake, a program/data preload port, and out-of-range error detection.

## Interface
- DATA_W, 16, word width of both memories and all data buses
- ADDR_W, 16, width of IA, DA, LD_ADDR
- IDEPTH, 128, instruction memory words
- DDEPTH, 128, data memory words
- WAIT_STATES, 0, extra cycles inserted before RDY on every data access (0..15)

Ports:
- CK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; synchronous, active-high
- IA  in  ADDR_W  instruction address
- ID  out  DATA_W  instruction word, registered
- DREQ  in  1  data access request
- DA  in  ADDR_W  data address
- RW  in  1  1 = read, 0 = write
- DD  inout  DATA_W  data bus; driven by this block only during a read response, Z otherwise
- RDY  out  1  one-cycle pulse marking completion of a data access
- LD_EN  in  1  preload write enable
- LD_SEL  in  1  preload target: 0 = IMEM, 1 = DMEM
- LD_ADDR  in  ADDR_W  preload address
- LD_DATA  in  DATA_W  preload word
- ERR  out  1  sticky out-of-range flag

## Operation
- Instruction port: every cycle ID <= IMEM[IA]. If IA >= IDEPTH, ID <= 0 and ERR sets. No handshake.
- Data FSM states:
  - IDLE: if DREQ=1 and LD_EN=0, latch DA, RW and DD (write data). Go to WAIT when WAIT_STATES>0, else RESP.
  - WAIT: a counter loaded with WAIT_STATES-1 decrements each cycle; at 0, go to RESP.
  - RESP: RDY=1 for exactly one cycle. For a read, DD is driven with the latched-address word. A write commits on the edge that enters RESP. Then go to IDLE.
- DREQ is sampled only in IDLE. DREQ high during WAIT or RESP is ignored. A held DREQ starts the next access in the IDLE cycle after RESP.
- Data address >= DDEPTH: a read returns 0, a write is dropped, ERR sets. Timing is unchanged and RDY still pulses.
- Preload: with LD_EN=1, LD_DATA is written to the memory selected by LD_SEL at LD_ADDR on that edge. One word per cycle, no wait states. An out-of-range LD_ADDR is dropped and sets ERR.
- LD_EN=1 blocks acceptance in IDLE. An access already in flight completes normally.
- If a preload write and a data write hit the same DMEM word on the same edge, the data write wins.
- ERR clears only on reset.

## Timing
- Reset values: ID=0, RDY=0, ERR=0, DD=Z, FSM=IDLE, counter=0. Memory contents are not cleared.
- Fetch latency: 1 cycle from IA to ID.
- Data latency: WAIT_STATES+1 cycles from the accepting edge to the RDY edge. Throughput is one access per WAIT_STATES+2 cycles.
- Read data on DD is valid only in the RDY cycle and returns to Z the following cycle.
- Reset mid-access: FSM returns to IDLE, no RDY is issued, and an uncommitted write is discarded.
- A DD read of a word written in the same RESP cycle returns the new value on the next access.

## Structure
- Package mem_unit_pkg holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - RW_READ=1 and RW_WRITE=0;
  - LD_IMEM=0 and LD_DMEM=1.
- Sub-module mem_unit_ram provides a synchronous-write, synchronous-read array with parameters DEPTH and DATA_W and one write port with priority select. It is instantiated once for IMEM and once for DMEM.
- Top level contains the FSM, wait counter, tristate control, range checks and the ERR register.

## Test plan
- Preload IMEM[0..2] = 0xC100, 0xC201, 0x0112 via LD_SEL=0, then IA=1 -> ID=0xC201 one cycle later. ID=0 while RST=1.
- WAIT_STATES=0: write 0x1234 to DA=5, then read DA=5 -> RDY pulses 1 cycle after each accept and DD=0x1234 in the read RDY cycle, Z otherwise.
- WAIT_STATES=3: read DA=7 -> RDY exactly 4 cycles after accept. DREQ held high throughout -> second accept on the cycle after RDY.
- DA=200 with DDEPTH=128: write then read -> RDY still pulses, read returns 0, ERR=1 and stays 1 until RST.
- LD_EN=1 while DREQ=1 in IDLE -> no accept until LD_EN drops. Same-edge preload and data write to DA=3 (0xAAAA vs 0x5555) -> DMEM[3]=0x5555.
- RST asserted during WAIT of a write 0xBEEF to DA=9 -> no RDY, DMEM[9] keeps its prior value, FSM=IDLE.
